// File: rtl/mul_seq_hs.sv
// rtl/mul_seq_hs.sv - iterative shift-add multiplier, fixed latency, valid/ready handshakes
module mul_seq_hs #(
  parameter int W              = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           signed_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] res,
  output logic           busy
);

  // Number of iterations per product and the counter width that indexes them.
  localparam int K  = W / BITS_PER_CYCLE;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Digit width must tile the operand exactly, otherwise the iteration count is wrong.
  generate
    if ((BITS_PER_CYCLE < 1) || ((W % BITS_PER_CYCLE) != 0)) begin : g_bad_bpc
      $error("mul_seq_hs: BITS_PER_CYCLE must be >= 1 and divide W");
    end
  endgenerate

  logic [1:0]     r_state;
  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] r_a_sh;   // |a| pre-shifted to the weight of the current digit
  logic [W-1:0]   r_b_mag;  // remaining multiplier digits, low digit first
  logic           r_sign;
  logic [2*W-1:0] r_acc;
  logic [2*W-1:0] r_res;

  logic           w_accept;
  logic           w_take;
  logic           w_last;
  logic [W-1:0]   w_a_mag;
  logic [W-1:0]   w_b_mag;
  logic           w_sign;
  logic [2*W-1:0] w_partial;
  logic [2*W-1:0] w_acc_next;
  logic [2*W-1:0] w_res_next;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign res       = r_res;

  assign w_accept = in_valid && in_ready;
  assign w_take   = out_valid && out_ready;
  assign w_last   = (r_cnt == CW'(K - 1));

  // Magnitudes: the two's-complement negation of -2^(W-1) is 2^(W-1) read as unsigned, so no overflow.
  assign w_a_mag = (signed_mode && a[W-1]) ? (~a + 1'b1) : a;
  assign w_b_mag = (signed_mode && b[W-1]) ? (~b + 1'b1) : b;
  assign w_sign  = signed_mode && (a[W-1] ^ b[W-1]);

  // One digit of the multiplier times |a|, built as a small shift-add tree.
  always_comb begin
    w_partial = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (r_b_mag[j]) begin
        w_partial = w_partial + (r_a_sh << j);
      end
    end
  end

  assign w_acc_next = r_acc + w_partial;
  // Negating a zero accumulator yields zero, so the sign needs no special case.
  assign w_res_next = r_sign ? (~w_acc_next + 1'b1) : w_acc_next;

  // Control FSM: accept in IDLE, run exactly K iterations, hold the result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (w_take) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Operand and accumulator datapath: latch magnitudes on accept, consume one digit per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh  <= '0;
      r_b_mag <= '0;
      r_sign  <= 1'b0;
      r_acc   <= '0;
    end else if (w_accept) begin
      r_a_sh  <= {{W{1'b0}}, w_a_mag};
      r_b_mag <= w_b_mag;
      r_sign  <= w_sign;
      r_acc   <= '0;
    end else if (r_state == S_RUN) begin
      r_a_sh  <= r_a_sh << BITS_PER_CYCLE;
      r_b_mag <= r_b_mag >> BITS_PER_CYCLE;
      r_acc   <= w_acc_next;
    end
  end

  // Result register: loaded on the final iteration edge and held until the next product completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res <= '0;
    end else if ((r_state == S_RUN) && w_last) begin
      r_res <= w_res_next;
    end
  end

endmodule
